// File: rtl/data_mem_lsu_pkg.sv
// data_mem_lsu_pkg: RV32I load/store size codes and LSU state encoding
package data_mem_lsu_pkg;
  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;
  typedef enum logic {INIT, IDLE} state_e;
endpackage

// File: rtl/data_mem_bank.sv
// data_mem_bank: DEPTH x 32 word array with byte write enables and registered read
module data_mem_bank #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: single-cycle-issue RV32I load/store unit over a self-clearing data memory
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            init_busy
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [AW-1:0] idx;
  logic accept, illegal, misal, oor, err, vld_q, err_q, ld_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [3:0] be, bank_we;
  logic [XLEN-1:0] wd, rdata, sh, ext;
  logic init;
  assign init = state_q == INIT;
  assign req_ready = !init && !rst;
  assign init_busy = init || rst;
  assign accept = req_valid && req_ready;
  assign oor = |req_addr[XLEN-1:AW+2];
  always_comb begin
    illegal = req_we ? req_funct3 > SW : req_funct3 inside {3'd3, 3'd6, 3'd7};
    misal = (req_funct3[1:0] == 2'd1 && req_addr[0]) || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    err = illegal || misal || oor;
    be = req_funct3[1:0] == 2'd0 ? 4'b0001 << req_addr[1:0] :
         req_funct3[1:0] == 2'd1 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'hF;
    wd = req_funct3[1:0] == 2'd0 ? {4{req_wdata[7:0]}} :
         req_funct3[1:0] == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
    bank_we = init ? 4'hF : (accept && req_we && !err) ? be : 4'h0;
  end
  data_mem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .addr (init ? idx : req_addr[AW+1:2]),
    .wdata(init ? '0 : wd),
    .rdata(rdata)
  );
  always_comb state_d = (init && idx == AW'(DEPTH - 1)) ? IDLE : state_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      idx <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      ld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx <= init ? idx + 1'b1 : idx;
      vld_q <= accept;
      err_q <= accept && err;
      ld_q <= accept && !req_we && !err;
    end
  end
  always_ff @(posedge clk) begin
    f3_q <= req_funct3;
    off_q <= req_addr[1:0];
  end
  // lane extraction works off the word read at the accept edge
  always_comb begin
    sh = rdata >> {off_q, 3'b000};
    ext = f3_q[1:0] == 2'd0 ? {{24{sh[7] && !f3_q[2]}}, sh[7:0]} :
          f3_q[1:0] == 2'd1 ? {{16{sh[15] && !f3_q[2]}}, sh[15:0]} : sh;
  end
  assign rsp_valid = vld_q && !rst;
  assign rsp_err = err_q && !rst;
  assign rsp_rdata = (ld_q && !rst) ? ext : '0;
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: table-driven scoreboard bench for data_mem_lsu
module tb_data_mem_lsu;
  import data_mem_lsu_pkg::*;
  localparam int DEPTH = 256;
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  logic clk = 0, rst = 1, req_valid = 0, req_ready, req_we = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
  logic rsp_valid, rsp_err, init_busy;
  int checks = 0, errors = 0, cyc = 0, n;
  vec_t tab[$];
  exp_t sb[$];
  exp_t e;

  data_mem_lsu #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_busy(init_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    tab.push_back('{we, f3, addr, wdata, rdata, err});
  endtask

  task automatic drive(input vec_t v);
    req_valid = 1;
    req_we = v.we;
    req_funct3 = v.f3;
    req_addr = v.addr;
    req_wdata = v.wdata;
    sb.push_back('{v.rdata, v.err, cyc + 1});
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic count_init(input string name);
    n = 0;
    while (init_busy && n < DEPTH + 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, n == DEPTH, n, DEPTH);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      chk("rsp_missing", 1'b0, 32'(cyc), 32'(e.due));
    end
    if (rsp_valid) begin
      if (sb.size() == 0) chk("rsp_unexpected", 1'b0, rsp_rdata, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_latency", cyc == e.due, 32'(cyc), 32'(e.due));
        chk("rsp_rdata", rsp_rdata == e.rdata, rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err == e.err, 32'(rsp_err), 32'(e.err));
      end
    end else chk("idle_zero", rsp_rdata == 0 && rsp_err == 0, {rsp_rdata[30:0], rsp_err}, 0);
  end

  initial begin
    add(0, LW, 32'h0, 0, 32'h0, 0);
    add(1, SW, 32'h10, 32'h80FF7F01, 0, 0);
    add(0, LB, 32'h10, 0, 32'h00000001, 0);
    add(0, LB, 32'h11, 0, 32'h0000007F, 0);
    add(0, LB, 32'h13, 0, 32'hFFFFFF80, 0);
    add(0, LBU, 32'h13, 0, 32'h00000080, 0);
    add(0, LH, 32'h12, 0, 32'hFFFF80FF, 0);
    add(0, LHU, 32'h12, 0, 32'h000080FF, 0);
    add(1, SW, 32'h20, 32'h11223344, 0, 0);
    add(1, SB, 32'h21, 32'h123456AA, 0, 0);
    add(0, LW, 32'h20, 0, 32'h1122AA44, 0);
    add(0, LH, 32'h3, 0, 0, 1);
    add(1, SW, 32'h6, 32'hDEADBEEF, 0, 1);
    add(0, LW, 32'(4 * DEPTH), 0, 0, 1);
    add(0, 3'd3, 32'h10, 0, 0, 1);
    add(1, 3'd4, 32'h10, 32'hFFFFFFFF, 0, 1);
    add(0, LW, 32'h4, 0, 32'h0, 0);
    add(0, LW, 32'h10, 0, 32'h80FF7F01, 0);
    add(1, SH, 32'h32, 32'h7777BEEF, 0, 0);
    add(0, LW, 32'h30, 0, 32'hBEEF0000, 0);
    add(0, LH, 32'h32, 0, 32'hFFFFBEEF, 0);
    add(0, LBU, 32'h31, 0, 32'h00000000, 0);
    for (int i = 0; i < 4; i++) begin
      add(1, SW, 32'h40 + 32'(4 * i), 32'hA5000000 + 32'(i * 32'h00010203), 0, 0);
      add(0, LW, 32'h40 + 32'(4 * i), 0, 32'hA5000000 + 32'(i * 32'h00010203), 0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_ready", req_ready == 0, 32'(req_ready), 0);
    chk("reset_busy", init_busy == 1, 32'(init_busy), 1);
    chk("reset_valid", rsp_valid == 0, 32'(rsp_valid), 0);
    rst = 0;
    count_init("init_cycles");
    chk("ready_after_init", req_ready == 1, 32'(req_ready), 1);
    foreach (tab[i]) drive(tab[i]);
    // store accepted, then reset lands in its response cycle: no response expected
    req_valid = 1;
    req_we = 1;
    req_funct3 = SW;
    req_addr = 32'h80;
    req_wdata = 32'h55555555;
    @(posedge clk);
    #1;
    req_valid = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    repeat (DEPTH / 2) @(posedge clk);
    #1;
    chk("busy_mid_init", init_busy == 1, 32'(init_busy), 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    count_init("init_restart_cycles");
    drive('{0, LW, 32'h80, 0, 32'h0, 0});
    drive('{0, LW, 32'h10, 0, 32'h0, 0});
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size() == 0, 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
